sap_output_display: RTL and testbench

//  Output stage of the SAP-1: captures the bus byte on an OUT instruction into the output register.

---
 rtl/sap_output_display_pkg.sv | 25 ++
 rtl/sap_output_display_bin2bcd_seq.sv | 50 +++++
 rtl/sap_output_display.sv | 57 +++++
 tb/tb_sap_output_display.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/sap_output_display_pkg.sv
// sap_output_display_pkg: shared segment patterns, converter states and BCD helpers.
package sap_output_display_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_H     = 7'b0001001;
  // Patterns are {g,f,e,d,c,b,a}, active-low, for a common-anode display.
  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    seg_digit = 7'b1000000;
      4'd1:    seg_digit = 7'b1111001;
      4'd2:    seg_digit = 7'b0100100;
      4'd3:    seg_digit = 7'b0110000;
      4'd4:    seg_digit = 7'b0011001;
      4'd5:    seg_digit = 7'b0010010;
      4'd6:    seg_digit = 7'b0000010;
      4'd7:    seg_digit = 7'b1111000;
      4'd8:    seg_digit = 7'b0000000;
      4'd9:    seg_digit = 7'b0010000;
      default: seg_digit = SEG_BLANK;
    endcase
  endfunction
  function automatic logic [3:0] add3(input logic [3:0] n);
    return n >= 4'd5 ? n + 4'd3 : n;
  endfunction
endpackage

// File: rtl/sap_output_display_bin2bcd_seq.sv
// sap_output_display_bin2bcd_seq: restartable double-dabble, one shift per cycle.
module sap_output_display_bin2bcd_seq
  import sap_output_display_pkg::*;
(
  input  logic        CLK,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  bin_in,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd_out
);
  state_t      state;
  logic [2:0]  cnt;
  logic [7:0]  bin;
  logic [11:0] bcd;
  logic [19:0] nxt;
  assign nxt     = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0]), bin} << 1;
  // A restart landing on the DONE cycle suppresses the result so it is never shown.
  assign done    = state == DONE && !start;
  assign bcd_out = bcd;
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      bin   <= '0;
      bcd   <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      state <= SHIFT;
      cnt   <= '0;
      bin   <= bin_in;
      bcd   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        SHIFT: begin
          {bcd, bin} <= nxt;
          cnt        <= cnt + 3'd1;
          state      <= cnt == 3'd7 ? DONE : SHIFT;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/sap_output_display.sv
// sap_output_display: SAP-1 output register, BCD conversion and 4-digit multiplexed 7-seg scan.
module sap_output_display
  import sap_output_display_pkg::*;
#(
  parameter int REFRESH_DIV = 16
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       load_out,
  input  logic [7:0] bus_in,
  input  logic       hlt,
  output logic [7:0] out_reg,
  output logic       busy,
  output logic [6:0] seg,
  output logic [3:0] an
);
  localparam int CW = REFRESH_DIV > 2 ? $clog2(REFRESH_DIV) : 1;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [3:0]    hd, td, ud;
  logic [11:0]   bcd;
  logic          done, wrap;
  logic [6:0]    seg_nxt;
  sap_output_display_bin2bcd_seq u_conv (
    .CLK     (CLK),
    .rst     (rst),
    .start   (load_out),
    .bin_in  (bus_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd)
  );
  assign wrap = cnt == CW'(REFRESH_DIV - 1);
  // Leading zeros are blanked; the status digit only shows H while halted.
  always_comb
    seg_nxt = idx == 2'd0 ? seg_digit(ud) :
              idx == 2'd1 ? (hd == 4'd0 && td == 4'd0 ? SEG_BLANK : seg_digit(td)) :
              idx == 2'd2 ? (hd == 4'd0 ? SEG_BLANK : seg_digit(hd)) :
              hlt ? SEG_H : SEG_BLANK;
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      out_reg      <= '0;
      {hd, td, ud} <= '0;
      cnt          <= '0;
      idx          <= '0;
      seg          <= seg_digit(4'd0);
      an           <= 4'b1110;
    end else begin
      if (load_out) out_reg <= bus_in;
      if (done) {hd, td, ud} <= bcd;
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap) idx <= idx + 2'd1;
      seg <= seg_nxt;
      an  <= ~(4'b0001 << idx);
    end
  end
endmodule

// File: tb/tb_sap_output_display.sv
// tb_sap_output_display: directed vector table plus hand-written reset/abort/scan sequences.
module tb_sap_output_display;
  logic       CLK = 1'b0;
  logic       rst = 1'b0;
  logic       load_out = 1'b0;
  logic [7:0] bus_in = '0;
  logic       hlt = 1'b0;
  logic [7:0] out_reg;
  logic       busy;
  logic [6:0] seg;
  logic [3:0] an;
  localparam logic [6:0] BL = 7'b1111111;
  int checks = 0;
  int failures = 0;
  logic [6:0] cap [4];
  logic mon_en = 1'b0;
  logic bad_h = 1'b0;
  typedef struct {
    logic [7:0] val;
    logic [6:0] s0, s1, s2;
  } vec_t;
  vec_t vt [10];
  sap_output_display #(.REFRESH_DIV(4)) dut (
    .CLK(CLK), .rst(rst), .load_out(load_out), .bus_in(bus_in), .hlt(hlt),
    .out_reg(out_reg), .busy(busy), .seg(seg), .an(an)
  );
  always #5 CLK = ~CLK;
  always @(negedge CLK) if (mon_en && an == 4'b1011 && seg !== BL) bad_h = 1'b1;
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic load(input logic [7:0] v);
    bus_in = v;
    load_out = 1'b1;
    tick();
    load_out = 1'b0;
  endtask
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 30) begin
      n++;
      tick();
    end
  endtask
  task automatic capture();
    for (int i = 0; i < 4; i++) cap[i] = 7'bx;
    tick();
    for (int i = 0; i < 16; i++) begin
      tick();
      case (an)
        4'b1110: cap[0] = seg;
        4'b1101: cap[1] = seg;
        4'b1011: cap[2] = seg;
        4'b0111: cap[3] = seg;
        default: ;
      endcase
    end
  endtask
  initial begin
    int n;
    logic [3:0] aseq [5];
    logic [3:0] prev;
    logic bad;
    vt[0] = '{8'd255, 7'b0010010, 7'b0010010, 7'b0100100};
    vt[1] = '{8'd7,   7'b1111000, BL,         BL};
    vt[2] = '{8'd40,  7'b1000000, 7'b0011001, BL};
    vt[3] = '{8'd0,   7'b1000000, BL,         BL};
    vt[4] = '{8'd100, 7'b1000000, 7'b1000000, 7'b1111001};
    vt[5] = '{8'd109, 7'b0010000, 7'b1000000, 7'b1111001};
    vt[6] = '{8'd250, 7'b1000000, 7'b0010010, 7'b0100100};
    vt[7] = '{8'd63,  7'b0110000, 7'b0000010, BL};
    vt[8] = '{8'd195, 7'b0010010, 7'b0010000, 7'b1111001};
    vt[9] = '{8'd34,  7'b0011001, 7'b0110000, BL};
    // reset held with a pending load
    bus_in = 8'hFF;
    load_out = 1'b1;
    repeat (3) tick();
    chk("rst_out_reg", out_reg, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_an", an, 4'b1110);
    chk("rst_seg", seg, 7'b1000000);
    rst = 1'b1;
    tick();
    load_out = 1'b0;
    chk("first_load", out_reg, 8'hFF);
    chk("first_busy", busy, 1'b1);
    wait_idle(n);
    chk("first_busy_len", n, 9);
    // vector table
    foreach (vt[k]) begin
      load(vt[k].val);
      chk($sformatf("out_reg_%0d", vt[k].val), out_reg, vt[k].val);
      wait_idle(n);
      chk($sformatf("busy_len_%0d", vt[k].val), n, 9);
      capture();
      chk($sformatf("idx0_%0d", vt[k].val), cap[0], vt[k].s0);
      chk($sformatf("idx1_%0d", vt[k].val), cap[1], vt[k].s1);
      chk($sformatf("idx2_%0d", vt[k].val), cap[2], vt[k].s2);
      chk($sformatf("idx3_%0d", vt[k].val), cap[3], BL);
    end
    // restart mid-conversion: 100 is aborted by 42
    mon_en = 1'b1;
    load(8'd100);
    n = 0;
    if (busy) n++;
    tick();
    if (busy) n++;
    load(8'd42);
    chk("abort_out_reg", out_reg, 8'd42);
    begin
      int m;
      wait_idle(m);
      n += m;
    end
    chk("abort_busy_len", n, 11);
    capture();
    mon_en = 1'b0;
    chk("abort_idx0", cap[0], 7'b0100100);
    chk("abort_idx1", cap[1], 7'b0011001);
    chk("abort_idx2", cap[2], BL);
    chk("abort_hidden", bad_h, 1'b0);
    // scan order and dwell
    aseq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    prev = an;
    n = 0;
    tick();
    while (!(an == 4'b1110 && prev != 4'b1110) && n < 20) begin
      prev = an;
      n++;
      tick();
    end
    chk("scan_sync", n < 20, 1'b1);
    for (int k = 0; k < 5; k++) begin
      bad = 1'b0;
      for (int j = 0; j < 4; j++) begin
        if (an !== aseq[k]) bad = 1'b1;
        tick();
      end
      chk($sformatf("scan_step_%0d", k), bad, 1'b0);
    end
    hlt = 1'b1;
    capture();
    chk("hlt_idx3", cap[3], 7'b0001001);
    chk("hlt_idx0", cap[0], 7'b0100100);
    hlt = 1'b0;
    // async reset mid-shift
    load(8'd200);
    tick();
    tick();
    #3 rst = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_out_reg", out_reg, 8'h00);
    chk("arst_seg", seg, 7'b1000000);
    chk("arst_an", an, 4'b1110);
    @(posedge CLK);
    #1 rst = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (busy) bad = 1'b1;
    end
    chk("arst_no_resume", bad, 1'b0);
    capture();
    chk("arst_idx0", cap[0], 7'b1000000);
    chk("arst_idx1", cap[1], BL);
    chk("arst_idx2", cap[2], BL);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
